// File: rtl/s2p_shift_register_pkg.sv
// Shared definitions for the serial/parallel link blocks.
//   S2P_WIDTH   : default serial bits per parallel word
//   s2p_word_t  : parallel word type, shared with the matching P2S block
package s2p_shift_register_pkg;

  localparam int unsigned S2P_WIDTH = 8;

  typedef logic [S2P_WIDTH-1:0] s2p_word_t;

endpackage

// File: rtl/s2p_shift_register.sv
// Serial-to-parallel converter on the receive side of the controller link.
// Bits on S_data_in are shifted in MSB-first (left shift) while read=0; on each
// edge with read=1 the assembled word is copied to P_data_out and the bit count
// clears.
// Ports:
//   P_data_out  out [WIDTH-1:0]  registered parallel word
//   reset       in               asynchronous active-low reset
//   ic_clk_ctrl in               clock, rising edge
//   S_data_in   in               serial data bit
//   read        in               0 = shift, 1 = transfer/hold
module s2p_shift_register
  import s2p_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = S2P_WIDTH
) (
  output logic [WIDTH-1:0] P_data_out,
  input  logic             reset,
  input  logic             ic_clk_ctrl,
  input  logic             S_data_in,
  input  logic             read
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;

  // Shift/count register. read takes priority, so a bit presented on the same
  // edge as the transfer is dropped rather than shifted in.
  always_ff @(posedge ic_clk_ctrl or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (read) begin
      bit_cnt <= '0;
    end else begin
      shift_q <= {shift_q[WIDTH-2:0], S_data_in};
      if (bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output register; reloading while read stays high keeps the word stable
  // because shift_q is frozen in read mode.
  always_ff @(posedge ic_clk_ctrl or negedge reset) begin
    if (!reset) begin
      P_data_out <= '0;
    end else if (read) begin
      P_data_out <= shift_q;
    end
  end

endmodule

// File: tb/tb_s2p_shift_register.sv
module tb_s2p_shift_register;

  logic       ic_clk_ctrl;
  logic       reset;
  logic       S_data_in;
  logic       read;
  logic [7:0] P_data_out;

  int checks = 0;
  int errors = 0;

  s2p_shift_register #(.WIDTH(8)) dut (
    .P_data_out  (P_data_out),
    .reset       (reset),
    .ic_clk_ctrl (ic_clk_ctrl),
    .S_data_in   (S_data_in),
    .read        (read)
  );

  // Clock starts late so the reset sequence runs with no edges at all.
  initial begin
    ic_clk_ctrl = 1'b0;
    #20;
    forever #5 ic_clk_ctrl = ~ic_clk_ctrl;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    @(negedge ic_clk_ctrl);
    read      = 1'b0;
    S_data_in = b;
    @(posedge ic_clk_ctrl);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic read_edge(input logic b);
    @(negedge ic_clk_ctrl);
    read      = 1'b1;
    S_data_in = b;
    @(posedge ic_clk_ctrl);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge ic_clk_ctrl);
    read  = 1'b0;
    #2 reset = 1'b0;
    #1 chk("reset_pulse", P_data_out, 8'h00);
    reset = 1'b1;
  endtask

  logic [9:0] ten_bits;

  initial begin
    reset     = 1'b1;
    S_data_in = 1'b0;
    read      = 1'b0;

    // 1: reset with no clock edges
    #2 reset = 1'b0;
    #1 chk("reset_asserted", P_data_out, 8'h00);
    #2 reset = 1'b1;
    #3 chk("reset_released", P_data_out, 8'h00);

    // 2: eight ones, output must hold until read
    for (int i = 0; i < 8; i++) begin
      shift_bit(1'b1);
      chk($sformatf("hold_during_shift_%0d", i), P_data_out, 8'h00);
    end
    read_edge(1'b0);
    chk("all_ones", P_data_out, 8'hFF);

    // 3: pattern B2
    shift_word(8'hB2);
    chk("hold_before_read_b2", P_data_out, 8'hFF);
    read_edge(1'b0);
    chk("pattern_b2", P_data_out, 8'hB2);

    // 4: partial word, then hold read high with toggling data
    pulse_reset();
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    read_edge(1'b0);
    chk("partial_07", P_data_out, 8'h07);
    for (int i = 0; i < 3; i++) begin
      read_edge(i[0] ? 1'b0 : 1'b1);
      chk($sformatf("read_hold_%0d", i), P_data_out, 8'h07);
    end

    // 5: ten bits, oldest two drop off the MSB
    ten_bits = 10'b1100000001;
    for (int i = 9; i >= 0; i--) shift_bit(ten_bits[i]);
    read_edge(1'b0);
    chk("overflow_01", P_data_out, 8'h01);

    // read on the edge of the last bit: that bit is not shifted in
    pulse_reset();
    for (int i = 0; i < 7; i++) shift_bit(i[0] ? 1'b0 : 1'b1);
    read_edge(1'b1);
    chk("read_wins_55", P_data_out, 8'h55);

    // 6: load FF, reset between edges, then transfer 5A
    shift_word(8'hFF);
    read_edge(1'b0);
    chk("load_ff", P_data_out, 8'hFF);
    pulse_reset();
    @(posedge ic_clk_ctrl);
    #1 chk("after_reset_edge", P_data_out, 8'h00);
    shift_word(8'h5A);
    read_edge(1'b0);
    chk("pattern_5a", P_data_out, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
